// File: rtl/kgs_pkg.sv
// kgs_pkg: shared constants, FSM states and directed vectors for the KGS adder BIST
//   KGS_SIZE/KGS_LL : default adder width convention and tree depth
//   KGS_POLY        : Galois toggle mask for x^32+x^22+x^2+x+1 (right-shift form)
//   kgs_state_e     : BIST controller states
//   KGS_DIR         : directed vectors as {a all-ones, b all-ones, cin}
package kgs_pkg;
    localparam int KGS_SIZE = 32;
    localparam int KGS_LL = 5;
    localparam logic [31:0] KGS_POLY = 32'h80200003;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} kgs_state_e;
    // entry 3 is filler so a 2-bit index never leaves the table
    localparam logic [3:0][2:0] KGS_DIR = {3'b111, 3'b111, 3'b101, 3'b000};
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? KGS_POLY : 32'h0);
    endfunction
endpackage

// File: rtl/kgs_adder_bist_if.sv
// kgs_adder_bist_if: operand/result bus between the BIST and the adder under test
//   a_o, b_o, cin_o : operands driven by the BIST (master)
//   sum_i, cout_i   : result returned by the adder (slave)
interface kgs_adder_bist_if import kgs_pkg::*; #(parameter int SIZE = KGS_SIZE);
    logic [SIZE-2:0] a_o;
    logic [SIZE-2:0] b_o;
    logic            cin_o;
    logic [SIZE-2:0] sum_i;
    logic            cout_i;
    modport master (output a_o, b_o, cin_o, input sum_i, cout_i);
    modport slave (input a_o, b_o, cin_o, output sum_i, cout_i);
endinterface

// File: rtl/kgs_lfsr32.sv
// kgs_lfsr32: 32-bit Galois LFSR with seed reload
//   clk, rst_n : clock, async active-low reset (reloads SEED)
//   load       : reload SEED (wins over en)
//   en         : advance one step
//   q          : current state
module kgs_lfsr32 import kgs_pkg::*; #(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    output logic [31:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= SEED;
        else q <= load ? SEED : en ? lfsr_next(q) : q;
endmodule

// File: rtl/kgs_adder_bist.sv
// kgs_adder_bist: stimulus generator and response checker for a KGS tree adder
//   clk, rst_n, start       : clock, async active-low reset, run request pulse
//   bus (master)            : a_o/b_o/cin_o to the adder, sum_i/cout_i back
//   busy, done, pass        : run status; pass only meaningful while done
//   err_cnt, first_err      : saturating mismatch count, lowest failing index
module kgs_adder_bist import kgs_pkg::*; #(
    parameter int          SIZE   = KGS_SIZE,
    parameter int          LL     = KGS_LL,
    parameter int          LAT    = 0,
    parameter int          NVEC   = 1024,
    parameter logic [31:0] SEED_A = 32'hACE10001,
    parameter logic [31:0] SEED_B = 32'h12345678
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    kgs_adder_bist_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_cnt,
    output logic [15:0]             first_err
);
    localparam int W = SIZE - 1;
    kgs_state_e st, nxt;
    logic [15:0] idx, nk, chk_i;
    logic [3:0] dcnt;
    logic acc, last, dlast, issue, chk_v, mism;
    logic [31:0] ra, rb;
    logic [2:0] dv;
    logic [W-1:0] va, vb;
    logic vc;
    logic [SIZE-1:0] cur_g, chk_g;
    logic unused_lfsr;

    if (SIZE < 2 || SIZE > 33 || LL < 1 || LAT < 0 || LAT > 15 || NVEC < 3 || NVEC > 65535 || SEED_A == 32'h0 || SEED_B == 32'h0) begin : g_bad
        $error("kgs_adder_bist: parameter out of range");
    end

    kgs_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst_n(rst_n), .load(acc), .en(issue && nk >= 16'd3), .q(ra));
    kgs_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst_n(rst_n), .load(acc), .en(issue && nk >= 16'd3), .q(rb));
    assign unused_lfsr = ^{ra, rb};

    always_comb begin
        acc = (st == IDLE || st == DONE) && start;
        last = st == RUN && idx == 16'(NVEC - 1);
        dlast = st == DRAIN && dcnt == 4'(LAT - 1);
        nxt = acc ? RUN : last ? (LAT == 0 ? DONE : DRAIN) : dlast ? DONE : st;
        issue = acc || (st == RUN && !last);
        nk = acc ? 16'd0 : idx + 16'd1;
        dv = KGS_DIR[nk[1:0]];
        va = nk < 16'd3 ? {W{dv[2]}} : ra[W-1:0];
        vb = nk < 16'd3 ? {W{dv[1]}} : rb[W-1:0];
        vc = nk < 16'd3 ? dv[0] : ra[31] ^ rb[31];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else st <= nxt;

    // operands are registered one cycle ahead so vector k sits on the bus for RUN cycle k
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx <= '0;
            dcnt <= '0;
            bus.a_o <= '0;
            bus.b_o <= '0;
            bus.cin_o <= 1'b0;
        end else begin
            idx <= issue ? nk : idx;
            dcnt <= st == DRAIN ? dcnt + 4'd1 : 4'd0;
            bus.a_o <= issue ? va : '0;
            bus.b_o <= issue ? vb : '0;
            bus.cin_o <= issue && vc;
        end

    assign cur_g = SIZE'(bus.a_o) + SIZE'(bus.b_o) + SIZE'(bus.cin_o);

    // golden+index line matches the adder's latency so each response meets its own vector
    if (LAT == 0) begin : g_direct
        assign chk_v = st == RUN;
        assign chk_g = cur_g;
        assign chk_i = idx;
    end else begin : g_line
        logic            lv [LAT];
        logic [SIZE-1:0] lg [LAT];
        logic [15:0]     li [LAT];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) begin
                    lv[i] <= 1'b0;
                    lg[i] <= '0;
                    li[i] <= '0;
                end
            end else begin
                lv[0] <= st == RUN;
                lg[0] <= cur_g;
                li[0] <= idx;
                for (int i = 1; i < LAT; i++) begin
                    lv[i] <= lv[i-1];
                    lg[i] <= lg[i-1];
                    li[i] <= li[i-1];
                end
            end
        assign chk_v = lv[LAT-1];
        assign chk_g = lg[LAT-1];
        assign chk_i = li[LAT-1];
    end

    assign mism = chk_v && ({bus.cout_i, bus.sum_i} != chk_g);

    // err_cnt never wraps, so zero reliably means no failure has been captured yet
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            err_cnt <= '0;
            first_err <= 16'hFFFF;
        end else if (acc) begin
            err_cnt <= '0;
            first_err <= 16'hFFFF;
        end else if (mism) begin
            err_cnt <= err_cnt == 16'hFFFF ? err_cnt : err_cnt + 16'd1;
            first_err <= err_cnt == 16'd0 ? chk_i : first_err;
        end

    assign busy = st == RUN || st == DRAIN;
    assign done = st == DONE;
    assign pass = done && err_cnt == 16'd0;
endmodule

// File: tb/tb_kgs_adder_bist.sv
// tb_kgs_adder_bist: three BIST instances (LAT 0/3/2) around behavioural adders with fault options
module tb_kgs_adder_bist;
    localparam int NV [3] = '{3, 1024, 64};
    localparam int LT [3] = '{0, 3, 2};
    localparam logic [31:0] POLY = 32'h80200003;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0] st = '0;
    logic [2:0] bs, dn, ps, co, ci;
    logic [2:0][15:0] ec, fe;
    logic [2:0][30:0] ao, bo;
    int fmode [3] = '{0, 0, 0};
    logic [30:0] va [1024];
    logic [30:0] vb [1024];
    logic vc [1024];
    int mc [3] = '{-1, -1, -1};
    bit mdone [3] = '{0, 0, 0};
    int eerr [3] = '{0, 0, 0};
    int efirst [3] = '{65535, 65535, 65535};
    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    logic [31:0] p1 [3];
    logic [31:0] p2 [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] gold(input logic [30:0] a, input logic [30:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {31'b0, c};
    endfunction

    // fault 1: cout stuck at 0; fault 2: sum bit 5 forced high on vector 700's operands
    function automatic logic [31:0] dut_add(input int f, input logic [30:0] a, input logic [30:0] b, input logic c);
        logic [31:0] r;
        r = gold(a, b, c);
        if (f == 1) r[31] = 1'b0;
        if (f == 2 && a == va[700] && b == vb[700] && c == vc[700]) r[5] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    kgs_adder_bist_if #(.SIZE(32)) b0 ();
    kgs_adder_bist_if #(.SIZE(32)) b1 ();
    kgs_adder_bist_if #(.SIZE(32)) b2 ();

    kgs_adder_bist #(.LAT(0), .NVEC(3)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .bus(b0.master),
        .busy(bs[0]), .done(dn[0]), .pass(ps[0]), .err_cnt(ec[0]), .first_err(fe[0]));
    kgs_adder_bist #(.LAT(3), .NVEC(1024)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .bus(b1.master),
        .busy(bs[1]), .done(dn[1]), .pass(ps[1]), .err_cnt(ec[1]), .first_err(fe[1]));
    kgs_adder_bist #(.LAT(2), .NVEC(64)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .bus(b2.master),
        .busy(bs[2]), .done(dn[2]), .pass(ps[2]), .err_cnt(ec[2]), .first_err(fe[2]));

    assign ao[0] = b0.a_o;
    assign bo[0] = b0.b_o;
    assign ci[0] = b0.cin_o;
    assign ao[1] = b1.a_o;
    assign bo[1] = b1.b_o;
    assign ci[1] = b1.cin_o;
    assign ao[2] = b2.a_o;
    assign bo[2] = b2.b_o;
    assign ci[2] = b2.cin_o;
    assign co = {b2.cout_i, b1.cout_i, b0.cout_i};

    assign {b0.cout_i, b0.sum_i} = dut_add(fmode[0], b0.a_o, b0.b_o, b0.cin_o);
    always @(posedge clk) begin
        p1[0] <= dut_add(fmode[1], b1.a_o, b1.b_o, b1.cin_o);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        p2[0] <= dut_add(fmode[2], b2.a_o, b2.b_o, b2.cin_o);
        p2[1] <= p2[0];
    end
    assign {b1.cout_i, b1.sum_i} = p1[2];
    assign {b2.cout_i, b2.sum_i} = p2[1];

    // model: mc = cycles since an accepted start; a run lasts NVEC+LAT cycles
    always @(posedge clk or negedge rst_n)
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mc[i] = -1;
                mdone[i] = 1'b0;
            end else if (mc[i] >= 0) begin
                mc[i]++;
                if (mc[i] == NV[i] + LT[i]) begin
                    mc[i] = -1;
                    mdone[i] = 1'b1;
                end
            end else if (st[i]) begin
                mc[i] = 0;
                mdone[i] = 1'b0;
                eerr[i] = 0;
                efirst[i] = 65535;
                for (int k = 0; k < NV[i]; k++)
                    if (dut_add(fmode[i], va[k], vb[k], vc[k]) != gold(va[k], vb[k], vc[k])) begin
                        if (eerr[i] == 0) efirst[i] = k;
                        eerr[i]++;
                    end
            end
        end

    always @(negedge clk)
        if (chk_en)
            for (int i = 0; i < 3; i++) begin
                logic [30:0] ea, eb;
                logic ecin;
                ea = '0;
                eb = '0;
                ecin = 1'b0;
                if (mc[i] >= 0 && mc[i] < NV[i]) begin
                    ea = va[mc[i]];
                    eb = vb[mc[i]];
                    ecin = vc[mc[i]];
                end
                chk($sformatf("u%0d_busy", i), bs[i], mc[i] >= 0);
                chk($sformatf("u%0d_done", i), dn[i], mdone[i]);
                chk($sformatf("u%0d_pass", i), ps[i], mdone[i] && eerr[i] == 0);
                chk($sformatf("u%0d_a", i), ao[i], ea);
                chk($sformatf("u%0d_b", i), bo[i], eb);
                chk($sformatf("u%0d_cin", i), ci[i], ecin);
                if (mc[i] < 0) begin
                    chk($sformatf("u%0d_err", i), ec[i], mdone[i] ? eerr[i] : 0);
                    chk($sformatf("u%0d_first", i), fe[i], mdone[i] ? efirst[i] : 65535);
                end
            end

    task automatic pulse(input int i);
        @(negedge clk);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic run_wait(input int i, input int bound, output int nb);
        nb = 0;
        for (int n = 0; n < bound && !dn[i]; n++) begin
            if (bs[i]) nb++;
            @(negedge clk);
        end
        chk($sformatf("u%0d_timeout", i), dn[i], 1);
    endtask

    initial begin
        logic [31:0] sa, sb, g;
        int nb;
        sa = 32'hACE10001;
        sb = 32'h12345678;
        for (int k = 0; k < 1024; k++)
            if (k < 3) begin
                va[k] = k == 0 ? 31'h0 : 31'h7FFFFFFF;
                vb[k] = k == 2 ? 31'h7FFFFFFF : 31'h0;
                vc[k] = k != 0;
            end else begin
                va[k] = sa[30:0];
                vb[k] = sb[30:0];
                vc[k] = sa[31] ^ sb[31];
                sa = nxt(sa);
                sb = nxt(sb);
            end
        chk("pin_va3", va[3], 31'h2CE10001);
        chk("pin_vb3", vb[3], 31'h12345678);
        chk("pin_vc3", vc[3], 1);
        chk("pin_va4", va[4], 31'h56508003);
        chk("pin_vb4", vb[4], 31'h091A2B3C);
        chk("pin_vc4", vc[4], 1);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_first", fe[1], 16'hFFFF);
        chk("rst_err", ec[1], 0);
        chk("rst_done", dn[1], 0);
        // scenario 1: LAT=0, three directed vectors
        pulse(0);
        chk("s1_a0", ao[0], 0);
        chk("s1_cin0", ci[0], 0);
        @(negedge clk);
        chk("s1_a1", ao[0], 31'h7FFFFFFF);
        chk("s1_b1", bo[0], 0);
        chk("s1_cout1", co[0], 1);
        @(negedge clk);
        chk("s1_a2", ao[0], 31'h7FFFFFFF);
        chk("s1_b2", bo[0], 31'h7FFFFFFF);
        @(negedge clk);
        chk("s1_done", dn[0], 1);
        chk("s1_pass", ps[0], 1);
        // scenario 2: LAT=3, clean adder
        pulse(1);
        run_wait(1, 1200, nb);
        chk("s2_busy_cycles", nb, 1027);
        chk("s2_err", ec[1], 0);
        chk("s2_first", fe[1], 16'hFFFF);
        chk("s2_pass", ps[1], 1);
        // scenario 4: single-vector fault at k=700
        fmode[1] = 2;
        g = gold(va[700], vb[700], vc[700]);
        pulse(1);
        run_wait(1, 1200, nb);
        chk("s4_err", ec[1], g[5] ? 0 : 1);
        chk("s4_first", fe[1], g[5] ? 16'hFFFF : 16'd700);
        // scenario 6: restart from DONE clears stats; start ignored during RUN
        fmode[1] = 0;
        pulse(1);
        chk("s6_err_clr", ec[1], 0);
        chk("s6_first_clr", fe[1], 16'hFFFF);
        chk("s6_busy", bs[1], 1);
        repeat (20) @(negedge clk);
        pulse(1);
        repeat (77) @(negedge clk);
        // scenario 5: reset mid-run, then rerun
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("s5_busy", bs[1], 0);
        chk("s5_done", dn[1], 0);
        chk("s5_first", fe[1], 16'hFFFF);
        chk("s5_a", ao[1], 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        pulse(1);
        run_wait(1, 1200, nb);
        chk("s5_busy_cycles", nb, 1027);
        chk("s5_err", ec[1], 0);
        chk("s5_pass", ps[1], 1);
        // randomized runs on the LAT=2 instance with spurious starts
        repeat (3) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            fmode[2] = $urandom_range(0, 1);
            pulse(2);
            repeat ($urandom_range(1, 30)) @(negedge clk);
            pulse(2);
            run_wait(2, 200, nb);
        end
        // scenario 3: cout stuck-at-0
        fmode[2] = 1;
        pulse(2);
        run_wait(2, 200, nb);
        chk("s3_first", fe[2], 1);
        chk("s3_pass", ps[2], 0);
        chk("s3_err_min", ec[2] >= 16'd2, 1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
